phase_code_pulse_gen: RTL and testbench

//  Downstream end of the transceiver GEN/SIGNAL_GEN_OVER handshake. One GEN request emits one

---
 rtl/pcg_pkg.sv | 22 ++
 rtl/pcg_chip_timer.sv | 38 +++
 rtl/phase_code_pulse_gen.sv | 156 +++++++++++++++
 tb/tb_phase_code_pulse_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pcg_pkg.sv
// Shared definitions for the phase-coded pulse generator: FSM encoding,
// PROBE_MODE values and the transmit-enable decode.
package pcg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHIP = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } pcg_state_e;

    localparam logic [7:0] MODE_TXRX = 8'd1;
    localparam logic [7:0] MODE_TX   = 8'd2;
    localparam logic [7:0] MODE_RX   = 8'd3;
    localparam logic [7:0] MODE_LOOP = 8'd4;

    // RF gate may open only in modes that actually radiate.
    function automatic logic tx_enabled(input logic [7:0] mode);
        return (mode == MODE_TXRX) || (mode == MODE_TX) || (mode == MODE_LOOP);
    endfunction

endpackage

// File: rtl/pcg_chip_timer.sv
// Chip timing: counts clocks within a chip and the chip index, flagging the
// last clock of each chip (chip_tick) and the final chip of the code (last_chip).
module pcg_chip_timer #(
    parameter int IDX_W = 6
) (
    input  logic             CLOCK_10M,
    input  logic             RESET,
    input  logic             clear,
    input  logic             run,
    input  logic [15:0]      cdur,
    input  logic [IDX_W-1:0] nchips,
    output logic             chip_tick,
    output logic             last_chip
);

    logic [15:0]      dur_cnt;
    logic [IDX_W-1:0] chip_idx;

    // cdur is never 0 here: the top substitutes 1 for a zero duration.
    assign chip_tick = run && (dur_cnt == (cdur - 16'd1));
    assign last_chip = (chip_idx == (nchips - IDX_W'(1)));

    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            dur_cnt  <= '0;
            chip_idx <= '0;
        end else if (clear) begin
            dur_cnt  <= '0;
            chip_idx <= '0;
        end else if (chip_tick) begin
            dur_cnt  <= '0;
            chip_idx <= chip_idx + IDX_W'(1);
        end else if (run) begin
            dur_cnt  <= dur_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/phase_code_pulse_gen.sv
// Emits one BPSK phase-coded pulse per GEN request and answers with
// SIGNAL_GEN_OVER. Outputs are registered from next-state values.
module phase_code_pulse_gen
    import pcg_pkg::*;
#(
    parameter int   MAX_CHIPS  = 32,
    parameter logic IDLE_PHASE = 1'b0
) (
    input  logic                 CLOCK_10M,
    input  logic                 RESET,
    input  logic                 GEN,
    input  logic [MAX_CHIPS-1:0] CODE,
    input  logic [15:0]          CODE_LEN,
    input  logic [15:0]          CODE_DURATION,
    input  logic [15:0]          PULSE_LEN,
    input  logic [7:0]           PROBE_MODE,
    output logic                 SIGNAL_GEN_OVER,
    output logic                 PHASE_BIT,
    output logic                 TX_GATE,
    output logic                 PULSE_ACTIVE,
    output pcg_state_e           dbg_state
);

    localparam int IDX_W = $clog2(MAX_CHIPS + 1);

    pcg_state_e           state, state_n;
    logic [MAX_CHIPS-1:0] code_sh;
    logic [IDX_W-1:0]     nchips_l;
    logic [15:0]          cdur_l, pulse_len_l, win_cnt, win_n, win_inc;
    logic [7:0]           mode_l;
    logic                 start, chip_tick, last_chip, pad_needed;
    logic                 over_n, phase_n, gate_n, active_n;

    logic [IDX_W-1:0]     nchips_in, shift_in;
    logic [15:0]          cdur_in;
    logic [MAX_CHIPS-1:0] code_in_sh;
    logic [31:0]          chip_total;

    assign nchips_in  = (CODE_LEN > 16'(MAX_CHIPS)) ? IDX_W'(MAX_CHIPS) : CODE_LEN[IDX_W-1:0];
    assign cdur_in    = (CODE_DURATION == 16'd0) ? 16'd1 : CODE_DURATION;
    // Left-align the active chips so the current chip is always the MSB.
    assign shift_in   = IDX_W'(MAX_CHIPS) - nchips_in;
    assign code_in_sh = CODE << shift_in;
    assign chip_total = 32'(nchips_l) * 32'(cdur_l);
    assign pad_needed = 32'(pulse_len_l) > chip_total;
    assign win_inc    = (&win_cnt) ? win_cnt : win_cnt + 16'd1;
    assign dbg_state  = state;

    pcg_chip_timer #(.IDX_W(IDX_W)) u_timer (
        .CLOCK_10M (CLOCK_10M),
        .RESET     (RESET),
        .clear     (start),
        .run       (state == ST_CHIP),
        .cdur      (cdur_l),
        .nchips    (nchips_l),
        .chip_tick (chip_tick),
        .last_chip (last_chip)
    );

    always_comb begin
        state_n  = state;
        win_n    = win_cnt;
        start    = 1'b0;
        over_n   = 1'b0;
        phase_n  = IDLE_PHASE;
        gate_n   = 1'b0;
        active_n = 1'b0;
        case (state)
            ST_IDLE: if (GEN) begin
                start    = 1'b1;
                win_n    = 16'd0;
                active_n = 1'b1;
                if (nchips_in == '0) begin
                    state_n = ST_PAD;
                end else begin
                    state_n = ST_CHIP;
                    phase_n = code_in_sh[MAX_CHIPS-1];
                    gate_n  = tx_enabled(PROBE_MODE);
                end
            end
            ST_CHIP: begin
                win_n = win_inc;
                if (!GEN) begin
                    state_n = ST_IDLE;
                    win_n   = 16'd0;
                end else if (chip_tick && last_chip) begin
                    if (pad_needed) begin
                        state_n  = ST_PAD;
                        active_n = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                        over_n  = 1'b1;
                    end
                end else begin
                    active_n = 1'b1;
                    gate_n   = tx_enabled(mode_l);
                    phase_n  = chip_tick ? code_sh[MAX_CHIPS-2] : code_sh[MAX_CHIPS-1];
                end
            end
            ST_PAD: begin
                if (!GEN) begin
                    state_n = ST_IDLE;
                    win_n   = 16'd0;
                end else if (win_inc >= pulse_len_l) begin
                    state_n = ST_DONE;
                    over_n  = 1'b1;
                end else begin
                    win_n    = win_inc;
                    active_n = 1'b1;
                end
            end
            ST_DONE: begin
                if (!GEN) state_n = ST_IDLE;
                else      over_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            state           <= ST_IDLE;
            win_cnt         <= '0;
            SIGNAL_GEN_OVER <= 1'b0;
            PHASE_BIT       <= IDLE_PHASE;
            TX_GATE         <= 1'b0;
            PULSE_ACTIVE    <= 1'b0;
        end else begin
            state           <= state_n;
            win_cnt         <= win_n;
            SIGNAL_GEN_OVER <= over_n;
            PHASE_BIT       <= phase_n;
            TX_GATE         <= gate_n;
            PULSE_ACTIVE    <= active_n;
        end
    end

    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            code_sh     <= '0;
            nchips_l    <= '0;
            cdur_l      <= '0;
            pulse_len_l <= '0;
            mode_l      <= '0;
        end else if (start) begin
            code_sh     <= code_in_sh;
            nchips_l    <= nchips_in;
            cdur_l      <= cdur_in;
            pulse_len_l <= PULSE_LEN;
            mode_l      <= PROBE_MODE;
        end else if (chip_tick) begin
            code_sh     <= code_sh << 1;
        end
    end

endmodule

// File: tb/tb_phase_code_pulse_gen.sv
// Directed bench for phase_code_pulse_gen: per-cycle output checks against
// an independent window model, plus abort, async reset and back-to-back runs.
module tb_phase_code_pulse_gen;
    import pcg_pkg::*;

    logic        CLOCK_10M = 1'b0;
    logic        RESET, GEN;
    logic [31:0] CODE;
    logic [15:0] CODE_LEN, CODE_DURATION, PULSE_LEN;
    logic [7:0]  PROBE_MODE;
    logic        SIGNAL_GEN_OVER, PHASE_BIT, TX_GATE, PULSE_ACTIVE;
    pcg_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    int over_rises = 0;
    logic prev_over = 1'b0;
    int g, a, o, snap;

    phase_code_pulse_gen dut (
        .CLOCK_10M       (CLOCK_10M),
        .RESET           (RESET),
        .GEN             (GEN),
        .CODE            (CODE),
        .CODE_LEN        (CODE_LEN),
        .CODE_DURATION   (CODE_DURATION),
        .PULSE_LEN       (PULSE_LEN),
        .PROBE_MODE      (PROBE_MODE),
        .SIGNAL_GEN_OVER (SIGNAL_GEN_OVER),
        .PHASE_BIT       (PHASE_BIT),
        .TX_GATE         (TX_GATE),
        .PULSE_ACTIVE    (PULSE_ACTIVE),
        .dbg_state       (dbg_state)
    );

    always #50 CLOCK_10M = ~CLOCK_10M;

    always @(posedge CLOCK_10M) begin
        if (SIGNAL_GEN_OVER && !prev_over) over_rises++;
        prev_over = SIGNAL_GEN_OVER;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_10M);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, SIGNAL_GEN_OVER, PHASE_BIT, TX_GATE, PULSE_ACTIVE};
    endfunction

    // One full handshake; returns TX_GATE and PULSE_ACTIVE cycle counts and
    // the 1-based clock (edge k = 1) on which OVER first appears.
    task automatic run_pulse(input string tag, input logic [31:0] c, input logic [15:0] l,
                             input logic [15:0] d, input logic [15:0] p, input logic [7:0] m,
                             output int gate_cnt, output int act_cnt, output int over_at);
        int n, cd, nt, w;
        logic tx;
        logic [31:0] e;
        n  = (l > 16'd32) ? 32 : int'(l);
        cd = (d == 16'd0) ? 1 : int'(d);
        nt = n * cd;
        w  = (int'(p) > nt) ? int'(p) : nt;
        if (w == 0) w = 1;
        tx = (m == 8'd1) || (m == 8'd2) || (m == 8'd4);
        CODE = c; CODE_LEN = l; CODE_DURATION = d; PULSE_LEN = p; PROBE_MODE = m;
        GEN = 1'b1;
        gate_cnt = 0; act_cnt = 0; over_at = -1;
        for (int i = 0; i <= w; i++) begin
            tick();
            if (i < nt)     e = {28'd0, 1'b0, c[n-1-i/cd], tx, 1'b1};
            else if (i < w) e = 32'b0001;
            else            e = 32'b1000;
            check(tag, outs(), e);
            gate_cnt += int'(TX_GATE);
            act_cnt  += int'(PULSE_ACTIVE);
            if (SIGNAL_GEN_OVER && over_at < 0) over_at = i + 1;
            if (i == 0) begin
                CODE = $urandom; CODE_LEN = 16'($urandom_range(0, 40));
                CODE_DURATION = 16'($urandom_range(0, 5)); PULSE_LEN = 16'($urandom_range(0, 50));
                PROBE_MODE = 8'($urandom_range(0, 5));
            end
        end
        repeat (2) begin
            tick();
            check({tag, "_over_held"}, outs(), 32'b1000);
        end
        GEN = 1'b0;
        tick();
        check({tag, "_over_drop"}, outs(), 32'b0000);
        tick();
    endtask

    initial begin
        RESET = 1'b1; GEN = 1'b0; CODE = '0; CODE_LEN = '0;
        CODE_DURATION = '0; PULSE_LEN = '0; PROBE_MODE = '0;
        repeat (3) @(posedge CLOCK_10M);
        #1;
        check("reset_outs", outs(), 32'b0000);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        RESET = 1'b0;
        tick();

        run_pulse("txrx", 32'h0000000B, 16'd4, 16'd3, 16'd20, 8'd1, g, a, o);
        check("txrx_gate_cnt", 32'(g), 32'd12);
        check("txrx_act_cnt", 32'(a), 32'd20);
        check("txrx_over_at", 32'(o), 32'd21);

        run_pulse("rx", 32'h0000000B, 16'd4, 16'd3, 16'd20, 8'd3, g, a, o);
        check("rx_gate_cnt", 32'(g), 32'd0);
        check("rx_act_cnt", 32'(a), 32'd20);
        check("rx_over_at", 32'(o), 32'd21);

        run_pulse("clamp", 32'hFFFFFFFF, 16'd40, 16'd1, 16'd10, 8'd4, g, a, o);
        check("clamp_act_cnt", 32'(a), 32'd32);
        check("clamp_over_at", 32'(o), 32'd33);

        run_pulse("empty", 32'h00000000, 16'd0, 16'd5, 16'd0, 8'd1, g, a, o);
        check("empty_act_cnt", 32'(a), 32'd1);
        check("empty_over_at", 32'(o), 32'd2);

        run_pulse("dur0", 32'h00000002, 16'd2, 16'd0, 16'd0, 8'd2, g, a, o);
        check("dur0_act_cnt", 32'(a), 32'd2);
        check("dur0_over_at", 32'(o), 32'd3);

        snap = over_rises;
        CODE = 32'h000000A5; CODE_LEN = 16'd8; CODE_DURATION = 16'd4;
        PULSE_LEN = 16'd40; PROBE_MODE = 8'd2; GEN = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            logic [31:0] c;
            c = 32'h000000A5;
            tick();
            check("abort_chip", outs(), {28'd0, 1'b0, c[7-i/4], 1'b1, 1'b1});
        end
        GEN = 1'b0;
        tick();
        check("abort_outs", outs(), 32'b0000);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) begin
            tick();
            check("abort_no_over", 32'(SIGNAL_GEN_OVER), 32'd0);
        end

        GEN = 1'b1; PROBE_MODE = 8'd1;
        repeat (5) tick();
        check("rst_pre_gate", 32'(TX_GATE), 32'd1);
        #40;
        RESET = 1'b1;
        #1;
        check("rst_async_outs", outs(), 32'b0000);
        check("rst_async_state", 32'(dbg_state), 32'(ST_IDLE));
        GEN = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        check("no_over_after_abort", 32'(over_rises - snap), 32'd0);

        snap = over_rises;
        for (int r = 0; r < 2; r++) begin
            run_pulse("b2b_a", 32'h00000005, 16'd3, 16'd2, 16'd8, 8'd1, g, a, o);
            check("b2b_a_over_at", 32'(o), 32'd9);
            run_pulse("b2b_b", 32'h0000F0F0, 16'd16, 16'd1, 16'd4, 8'd3, g, a, o);
            check("b2b_b_over_at", 32'(o), 32'd17);
            run_pulse("b2b_c", 32'h00000001, 16'd1, 16'd2, 16'd5, 8'd4, g, a, o);
            check("b2b_c_over_at", 32'(o), 32'd6);
        end
        repeat (2) tick();
        check("b2b_handshakes", 32'(over_rises - snap), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
